fetch_align: RTL and testbench
==============================

FETCH_ALIGN -- requirements
Module: fetch_align

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC of the first instruction after reset.
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 i_flush  input  1  redirect; discard buffered state and restart fetch alignment at i_flush_pc.
REQ-005 i_flush_pc  input  32  redirect target, halfword aligned; bit 0 ignored.
REQ-006 i_word  input  32  aligned fetch word; [15:0] = lower halfword, [31:16] = upper halfword.
REQ-007 i_word_valid  input  1  i_word holds the next sequential fetch word.
REQ-008 o_word_ready  output  1  word consumed this cycle when i_word_valid && o_word_ready.
REQ-009 o_instruction  output  32  aligned instruction; [31:16] zero when compressed.
REQ-010 o_compressed  output  1  o_instruction[15:0] is an RVC halfword (bits [1:0] != 2'b11).
REQ-011 o_pc  output  32  PC of o_instruction.
REQ-012 o_valid  output  1  instruction presented; held stable until accepted.
REQ-013 i_ready  input  1  downstream (RVC expander/decode) accepts when o_valid && i_ready.

Function
REQ-014 State register has three states: EMPTY (no halfword buffered), HALF (one halfword in hold[15:0]), DROP (discard lower halfword of next word).
REQ-015 Internal pc[31:0] holds the PC of the next instruction to emit; it advances by 2 (compressed) or 4 (32-bit) on each output handshake.
REQ-016 EMPTY with lower halfword compressed: o_valid = i_word_valid, emit {16'b0, lower halfword}; on handshake, consume word, hold <= upper halfword, go HALF.
REQ-017 EMPTY with lower halfword not compressed: o_valid = i_word_valid, emit i_word; on handshake, consume word, stay EMPTY.
REQ-018 HALF with hold compressed: o_valid = 1 regardless of input, emit {16'b0, hold}, o_word_ready = 0; on handshake go EMPTY.
REQ-019 HALF with hold not compressed: o_valid = i_word_valid, emit {i_word[15:0], hold}; on handshake, consume word, hold <= i_word[31:16], stay HALF.
REQ-020 DROP: o_valid = 0, o_word_ready = 1; on word acceptance, hold <= i_word[31:16], go HALF; pc unchanged.
REQ-021 Outside DROP, o_word_ready = i_ready in the consuming cases (REQ-016, 017, 019), else 0; this combinational path is intended.
REQ-022 Compressed test is bits [1:0] != 2'b11; lengths above 32 bits are not supported, so any 2'b11 halfword is treated as 32-bit.
REQ-023 While o_valid = 1 and i_ready = 0, o_instruction, o_compressed and o_pc remain stable.
REQ-024 i_flush = 1 forces o_valid = 0 and o_word_ready = 0 that cycle; next state is DROP if i_flush_pc[1] = 1, else EMPTY.
REQ-025 On i_flush, pc <= {i_flush_pc[31:1], 1'b0} and hold is invalidated.
REQ-026 i_flush has priority over any handshake in the same cycle; no word is consumed and no instruction is delivered.
REQ-027 pc wraps modulo 2^32 with no error indication.

Reset
REQ-028 On i_rst, state = EMPTY, pc = RESET_PC, hold = 16'h0000.
REQ-029 During reset and the first cycle after it, o_valid = 0 and o_word_ready = 0; o_instruction = 0, o_compressed = 0, o_pc = RESET_PC.
REQ-030 i_rst overrides i_flush and any handshake.
REQ-031 Reset asserted mid-straddle discards hold with no output.
REQ-032 If RESET_PC[1] = 1, the post-reset state is DROP.

Structure
REQ-033 State enum type (EMPTY/HALF/DROP) and the halfword-is-compressed function reside in package common.
REQ-034 No sub-module; the RVC expander remains a separate downstream block.

Verification
REQ-035 Reset, then i_word = 32'h0000_0013 -> emit 32'h0000_0013, o_compressed = 0, o_pc = 0x0, state EMPTY.
REQ-036 i_word = 32'h4501_0505 -> emit 32'h0000_0505 at pc 0x0, then 32'h0000_4501 at pc 0x2 with o_word_ready = 0 in the second cycle.
REQ-037 Words 32'h0013_0505 then 32'h0505_0000 -> emit 0x0505 @0x0 (c = 1), 0x0000_0013 @0x2 (c = 0), 0x0505 @0x6 (c = 1).
REQ-038 Flush to 0x102, then i_word = 32'h0505_4501 -> no output for the dropped 0x4501; emit 32'h0000_0505 at pc 0x102.
REQ-039 i_ready held 0 for 3 cycles mid-straddle -> outputs stable, no word consumed; release -> exactly one delivery.
REQ-040 Flush coinciding with a valid handshake, and reset in HALF -> no instruction delivered, no word consumed; state and pc per REQ-024/028.

Source files
------------

// File: rtl/fetch_align_pkg.sv
// Shared fetch-alignment types and helpers.
// Holds the alignment state encoding and the RVC length test.
package common;

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    DROP
  } fa_state_e;

  // Anything other than 2'b11 in the low bits is a 16-bit RVC parcel.
  function automatic logic is_rvc(input logic [15:0] h);
    return h[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_align.sv
// Realigns 32-bit fetch words into 16/32-bit instructions.
// Tracks a buffered upper halfword across word boundaries.
module fetch_align
  import common::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_flush,
  input  logic [31:0] i_flush_pc,
  input  logic [31:0] i_word,
  input  logic        i_word_valid,
  output logic        o_word_ready,
  output logic [31:0] o_instruction,
  output logic        o_compressed,
  output logic [31:0] o_pc,
  output logic        o_valid,
  input  logic        i_ready
);

  fa_state_e   state;
  fa_state_e   state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [15:0] hold;
  logic [15:0] hold_nxt;
  logic        init;

  logic        blk;
  logic        lo_c;
  logic        hd_c;
  logic        fire;
  logic        take;
  logic        unused_ok;

  assign unused_ok = i_flush_pc[0];

  assign lo_c = is_rvc(i_word[15:0]);
  assign hd_c = is_rvc(hold);
  // Reset, the cycle after it, and redirects all suppress handshakes.
  assign blk  = i_rst | init | i_flush;

  always_comb begin
    o_valid       = 1'b0;
    o_word_ready  = 1'b0;
    o_instruction = '0;
    o_compressed  = 1'b0;
    o_pc          = pc;
    unique case (1'b1)
      (state == EMPTY): begin
        o_valid       = i_word_valid;
        o_word_ready  = i_ready;
        o_compressed  = lo_c;
        o_instruction = lo_c ? {16'h0000, i_word[15:0]}
                             : i_word;
      end
      (state == HALF): begin
        if (hd_c) begin
          o_valid       = 1'b1;
          o_compressed  = 1'b1;
          o_instruction = {16'h0000, hold};
        end else begin
          o_valid       = i_word_valid;
          o_word_ready  = i_ready;
          o_instruction = {i_word[15:0], hold};
        end
      end
      (state == DROP): begin
        o_word_ready = 1'b1;
      end
      default: begin
        o_valid = 1'b0;
      end
    endcase
    if (blk) begin
      o_valid      = 1'b0;
      o_word_ready = 1'b0;
    end
    if (i_rst | init) begin
      o_instruction = '0;
      o_compressed  = 1'b0;
      o_pc          = RESET_PC;
    end
  end

  assign fire = o_valid & i_ready;
  assign take = i_word_valid & o_word_ready;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    hold_nxt  = hold;
    if (i_flush) begin
      state_nxt = i_flush_pc[1] ? DROP : EMPTY;
      pc_nxt    = {i_flush_pc[31:1], 1'b0};
      hold_nxt  = '0;
    end else begin
      if (fire) begin
        pc_nxt = pc + (o_compressed ? 32'd2 : 32'd4);
      end
      unique case (1'b1)
        (state == EMPTY): begin
          if (fire && lo_c) begin
            hold_nxt  = i_word[31:16];
            state_nxt = HALF;
          end
        end
        (state == HALF): begin
          if (fire) begin
            if (hd_c) begin
              state_nxt = EMPTY;
            end else begin
              hold_nxt = i_word[31:16];
            end
          end
        end
        (state == DROP): begin
          if (take) begin
            hold_nxt  = i_word[31:16];
            state_nxt = HALF;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= RESET_PC[1] ? DROP : EMPTY;
      pc    <= RESET_PC;
      hold  <= '0;
      init  <= 1'b1;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      hold  <= hold_nxt;
      init  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_align.sv
// Self-checking bench for fetch_align.
// Word source queue feeds the DUT; a scoreboard checks deliveries.
module tb_fetch_align;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_flush;
  logic [31:0] i_flush_pc;
  logic [31:0] i_word;
  logic        i_word_valid;
  logic        o_word_ready;
  logic [31:0] o_instruction;
  logic        o_compressed;
  logic [31:0] o_pc;
  logic        o_valid;
  logic        i_ready;

  fetch_align #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_flush      (i_flush),
    .i_flush_pc   (i_flush_pc),
    .i_word       (i_word),
    .i_word_valid (i_word_valid),
    .o_word_ready (o_word_ready),
    .o_instruction(o_instruction),
    .o_compressed (o_compressed),
    .o_pc         (o_pc),
    .o_valid      (o_valid),
    .i_ready      (i_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic        comp;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    int              nw;
    logic [1:0][31:0] w;
    int              ne;
    logic [2:0][31:0] ei;
    logic [2:0]       ec;
    logic [2:0][31:0] ep;
  } vec_t;

  localparam int NV = 6;

  vec_t        vt [NV];
  logic [31:0] words [$];
  exp_t        exp_q [$];
  int          tests = 0;
  int          fails = 0;
  logic        take_n = 1'b0;

  task automatic refresh();
    i_word_valid = words.size() > 0;
    i_word       = (words.size() > 0) ? words[0] : 32'h0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, act, expv);
    end
  endtask

  // Scoreboard and word-consumption tracking, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    take_n = i_word_valid && o_word_ready;
    if (o_valid && i_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL extra_out got instr=%h pc=%h", o_instruction, o_pc);
      end else begin
        e = exp_q.pop_front();
        if (o_instruction !== e.instr || o_compressed !== e.comp ||
            o_pc !== e.pc) begin
          fails++;
          $display("FAIL deliver got %h/%b@%h exp %h/%b@%h",
                   o_instruction, o_compressed, o_pc,
                   e.instr, e.comp, e.pc);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (take_n && words.size() > 0) begin
      void'(words.pop_front());
    end
    take_n = 1'b0;
    refresh();
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push_e(input logic [31:0] ins, input logic c,
                        input logic [31:0] p);
    exp_q.push_back('{instr: ins, comp: c, pc: p});
  endtask

  task automatic wait_done(input string nm, input int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout got=%0d pending exp=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    i_rst   = 1'b1;
    i_flush = 1'b0;
    words.delete();
    exp_q.delete();
    refresh();
    tick();
    i_rst = 1'b0;
  endtask

  task automatic setv(input int k, input int nw, input logic [31:0] w0,
                      input logic [31:0] w1);
    vt[k].nw   = nw;
    vt[k].w[0] = w0;
    vt[k].w[1] = w1;
    vt[k].ne   = 0;
    vt[k].ei   = '0;
    vt[k].ec   = '0;
    vt[k].ep   = '0;
  endtask

  task automatic sete(input int k, input logic [31:0] ins, input logic c,
                      input logic [31:0] p);
    vt[k].ei[vt[k].ne] = ins;
    vt[k].ec[vt[k].ne] = c;
    vt[k].ep[vt[k].ne] = p;
    vt[k].ne++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst      = 1'b1;
    i_flush    = 1'b0;
    i_flush_pc = 32'h0;
    i_ready    = 1'b1;
    words.push_back(32'h0000_0013);
    refresh();

    setv(0, 1, 32'h0505_4501, 32'h0);
    sete(0, 32'h0000_4501, 1'b1, 32'h0);
    sete(0, 32'h0000_0505, 1'b1, 32'h2);
    setv(1, 2, 32'h0013_0505, 32'h0505_0000);
    sete(1, 32'h0000_0505, 1'b1, 32'h0);
    sete(1, 32'h0000_0013, 1'b0, 32'h2);
    sete(1, 32'h0000_0505, 1'b1, 32'h6);
    setv(2, 2, 32'h00a0_0093, 32'h00b0_0113);
    sete(2, 32'h00a0_0093, 1'b0, 32'h0);
    sete(2, 32'h00b0_0113, 1'b0, 32'h4);
    setv(3, 2, 32'h0093_0001, 32'h0113_00a0);
    sete(3, 32'h0000_0001, 1'b1, 32'h0);
    sete(3, 32'h00a0_0093, 1'b0, 32'h2);
    setv(4, 1, 32'hffff_ffff, 32'h0);
    sete(4, 32'hffff_ffff, 1'b0, 32'h0);
    setv(5, 1, 32'h0000_0002, 32'h0);
    sete(5, 32'h0000_0002, 1'b1, 32'h0);
    sete(5, 32'h0000_0000, 1'b1, 32'h2);

    // Reset and the cycle after it stay silent even with a word offered.
    @(negedge clk);
    chk("rst_valid", {31'h0, o_valid}, 32'h0);
    chk("rst_wready", {31'h0, o_word_ready}, 32'h0);
    chk("rst_instr", o_instruction, 32'h0);
    chk("rst_comp", {31'h0, o_compressed}, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    chk("init_valid", {31'h0, o_valid}, 32'h0);
    chk("init_wready", {31'h0, o_word_ready}, 32'h0);
    chk("init_pc", o_pc, 32'h0);
    push_e(32'h0000_0013, 1'b0, 32'h0);
    wait_done("first", 20);
    repeat (3) tick();

    for (int k = 0; k < NV; k++) begin
      do_reset();
      for (int j = 0; j < vt[k].nw; j++) words.push_back(vt[k].w[j]);
      for (int j = 0; j < vt[k].ne; j++)
        push_e(vt[k].ei[j], vt[k].ec[j], vt[k].ep[j]);
      refresh();
      wait_done("vec", 40);
      repeat (3) tick();
    end

    // Buffered RVC half is emitted without consuming the waiting word.
    do_reset();
    words.push_back(32'h4501_0505);
    words.push_back(32'h0000_0013);
    refresh();
    push_e(32'h0000_0505, 1'b1, 32'h0);
    push_e(32'h0000_4501, 1'b1, 32'h2);
    push_e(32'h0000_0013, 1'b0, 32'h4);
    tick();
    @(negedge clk);
    chk("c1_wready", {31'h0, o_word_ready}, 32'h1);
    tick();
    @(negedge clk);
    chk("c2_wready", {31'h0, o_word_ready}, 32'h0);
    chk("c2_pc", o_pc, 32'h2);
    wait_done("rvc_pair", 20);
    repeat (3) tick();

    // Redirect to odd halfword drops the lower parcel.
    i_rst = 1'b1;
    words.delete();
    exp_q.delete();
    words.push_back(32'h0505_4501);
    refresh();
    tick();
    i_rst      = 1'b0;
    i_flush    = 1'b1;
    i_flush_pc = 32'h0000_0102;
    @(negedge clk);
    chk("fl_valid", {31'h0, o_valid}, 32'h0);
    chk("fl_wready", {31'h0, o_word_ready}, 32'h0);
    tick();
    i_flush = 1'b0;
    @(negedge clk);
    chk("drop_valid", {31'h0, o_valid}, 32'h0);
    chk("drop_wready", {31'h0, o_word_ready}, 32'h1);
    push_e(32'h0000_0505, 1'b1, 32'h102);
    wait_done("drop", 20);
    repeat (3) tick();

    // Flush beats a ready handshake; the word survives to the new pc.
    do_reset();
    tick();
    words.push_back(32'h0000_0013);
    refresh();
    i_flush    = 1'b1;
    i_flush_pc = 32'h0000_0200;
    @(negedge clk);
    chk("flhs_valid", {31'h0, o_valid}, 32'h0);
    chk("flhs_wready", {31'h0, o_word_ready}, 32'h0);
    tick();
    i_flush = 1'b0;
    chk("flhs_kept", words.size(), 32'd1);
    push_e(32'h0000_0013, 1'b0, 32'h200);
    wait_done("flhs", 20);
    repeat (3) tick();

    // PC wraps through zero; flush pc bit 0 ignored.
    do_reset();
    i_flush    = 1'b1;
    i_flush_pc = 32'hffff_fffd;
    tick();
    i_flush = 1'b0;
    words.push_back(32'h00a0_0093);
    words.push_back(32'h0000_0001);
    refresh();
    push_e(32'h00a0_0093, 1'b0, 32'hffff_fffc);
    push_e(32'h0000_0001, 1'b1, 32'h0);
    push_e(32'h0000_0000, 1'b1, 32'h2);
    wait_done("wrap", 30);
    repeat (3) tick();

    // Stall mid-straddle holds outputs and the word.
    do_reset();
    words.push_back(32'h0093_0001);
    words.push_back(32'h0113_00a0);
    refresh();
    push_e(32'h0000_0001, 1'b1, 32'h0);
    wait_done("st_pre", 20);
    i_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("st_valid", {31'h0, o_valid}, 32'h1);
      chk("st_instr", o_instruction, 32'h00a0_0093);
      chk("st_pc", o_pc, 32'h2);
      chk("st_wready", {31'h0, o_word_ready}, 32'h0);
      tick();
      chk("st_kept", words.size(), 32'd1);
    end
    push_e(32'h00a0_0093, 1'b0, 32'h2);
    i_ready = 1'b1;
    wait_done("st_rel", 10);
    repeat (3) tick();
    chk("st_left", words.size(), 32'd0);

    // Reset while straddling discards the held half.
    do_reset();
    words.push_back(32'h0093_0001);
    refresh();
    push_e(32'h0000_0001, 1'b1, 32'h0);
    wait_done("rh_pre", 20);
    words.push_back(32'h0113_00a0);
    refresh();
    i_rst = 1'b1;
    @(negedge clk);
    chk("rh_valid", {31'h0, o_valid}, 32'h0);
    chk("rh_wready", {31'h0, o_word_ready}, 32'h0);
    tick();
    i_rst = 1'b0;
    @(negedge clk);
    chk("rh_init_pc", o_pc, 32'h0);
    chk("rh_kept", words.size(), 32'd1);
    push_e(32'h0000_00a0, 1'b1, 32'h0);
    wait_done("rh", 20);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
